// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2/stride-2 max pooling over K packed signed lanes per beat.
// Even rows fold horizontal pairs into a half-row line buffer; odd rows complete each window.
module maxpool2x2_stream #(
  parameter int K          = 3,
  parameter int SRAM_WIDTH = 32,
  parameter int ROW_WIDTH  = 56,
  parameter int ROWS       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [K*SRAM_WIDTH-1:0] DATAIN,
  output logic                    out_valid,
  output logic [K*SRAM_WIDTH-1:0] DATAOUT,
  output logic                    frame_done
);

  localparam int W    = K * SRAM_WIDTH;
  localparam int HALF = ROW_WIDTH / 2;
  localparam int CW   = $clog2(ROW_WIDTH);
  localparam int RWD  = $clog2(ROWS);
  localparam logic [CW-1:0]  COL_LAST = CW'(ROW_WIDTH - 1);
  localparam logic [RWD-1:0] ROW_LAST = RWD'(ROWS - 1);

  function automatic logic [W-1:0] lane_max(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [SRAM_WIDTH-1:0] la;
    logic signed [SRAM_WIDTH-1:0] lb;
    logic [W-1:0]                 r;
    r = '0;
    for (int k = 0; k < K; k++) begin
      la = a[k*SRAM_WIDTH +: SRAM_WIDTH];
      lb = b[k*SRAM_WIDTH +: SRAM_WIDTH];
      r[k*SRAM_WIDTH +: SRAM_WIDTH] = (la > lb) ? la : lb;
    end
    return r;
  endfunction

  logic [CW-1:0]  col_q, col_d;
  logic [RWD-1:0] row_q, row_d;
  logic [W-1:0]   pair_q, pair_d;
  logic [W-1:0]   linebuf_q [HALF];
  logic [W-1:0]   linebuf_d [HALF];
  logic [W-1:0]   dout_q, dout_d;
  logic           ovalid_q, ovalid_d;
  logic           fdone_q, fdone_d;
  logic [CW-2:0]  idx;
  logic [W-1:0]   hmax;
  logic [W-1:0]   vmax;

  assign idx = col_q[CW-1:1];

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    pair_d    = pair_q;
    linebuf_d = linebuf_q;
    dout_d    = dout_q;
    ovalid_d  = 1'b0;
    fdone_d   = 1'b0;
    hmax      = lane_max(pair_q, DATAIN);
    vmax      = lane_max(linebuf_q[idx], hmax);
    if (in_valid) begin
      if (!col_q[0]) begin
        pair_d = DATAIN;
      end else if (!row_q[0]) begin
        linebuf_d[idx] = hmax;
      end else begin
        dout_d   = vmax;
        ovalid_d = 1'b1;
        fdone_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
      // Row and frame wrap happen together on the last beat of a row.
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      pair_q    <= '0;
      linebuf_q <= '{default: '0};
      dout_q    <= '0;
      ovalid_q  <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      pair_q    <= pair_d;
      linebuf_q <= linebuf_d;
      dout_q    <= dout_d;
      ovalid_q  <= ovalid_d;
      fdone_q   <= fdone_d;
    end
  end

  assign out_valid  = ovalid_q;
  assign DATAOUT    = dout_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: the driver pushes expected pooled beats,
// a negedge monitor pops and compares value, frame_done and arrival cycle.
module tb_maxpool2x2_stream;

  localparam int K  = 3;
  localparam int SW = 32;
  localparam int RW = 56;
  localparam int RS = 32;
  localparam int W  = K * SW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] DATAIN = '0;
  logic         out_valid;
  logic [W-1:0] DATAOUT;
  logic         frame_done;

  maxpool2x2_stream #(.K(K), .SRAM_WIDTH(SW), .ROW_WIDTH(RW), .ROWS(RS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .DATAIN(DATAIN),
    .out_valid(out_valid), .DATAOUT(DATAOUT), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         fd;
    int           due;
  } exp_t;

  exp_t         sb [$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           fd_count = 0;
  int           out_count = 0;

  // golden model state: a full copy of the last even row plus the current odd-row pair
  logic [W-1:0] even_row [RW];
  logic [W-1:0] prev_beat;
  int           mr = 0;
  int           mc = 0;
  bit           formula_mode = 0;
  bit           hand_pending = 0;
  logic [W-1:0] hand_val;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] pmax(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < K; k++)
      r[k*SW +: SW] = ($signed(a[k*SW +: SW]) > $signed(b[k*SW +: SW])) ? a[k*SW +: SW] : b[k*SW +: SW];
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model(input logic [W-1:0] d);
    exp_t e;
    int   i, j;
    if (mr % 2 == 0) begin
      even_row[mc] = d;
    end else if (mc % 2 == 0) begin
      prev_beat = d;
    end else begin
      i = mr / 2;
      j = mc / 2;
      e.data = pmax(pmax(even_row[mc-1], even_row[mc]), pmax(prev_beat, d));
      if (formula_mode) e.data = {K{SW'((2*i+1)*RW + 2*j + 1)}};
      if (hand_pending) begin
        e.data = hand_val;
        hand_pending = 0;
      end
      e.fd  = (mr == RS-1) && (mc == RW-1);
      e.due = cyc + 1;
      sb.push_back(e);
    end
    if (mc == RW-1) begin
      mc = 0;
      mr = (mr == RS-1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic send_beat(input logic [W-1:0] d, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      DATAIN   = {W{1'b1}};
    end
    @(negedge clk);
    in_valid = 1'b1;
    DATAIN   = d;
    model(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      budget--;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected outputs never arrived", name, sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [W-1:0] rnd_beat();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: compares every presented output with the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (sb.size() != 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_output: none at cycle %0d expected %h", e.due, e.data);
      end
      if (frame_done && !out_valid) begin
        checks++;
        errors++;
        $display("FAIL frame_done_alone: frame_done=1 out_valid=0 required 0 at cycle %0d", cyc);
      end
      if (out_valid) begin
        out_count++;
        if (frame_done) fd_count++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h with empty scoreboard at cycle %0d", DATAOUT, cyc);
        end else begin
          e = sb.pop_front();
          check("dataout", DATAOUT, e.data);
          check("frame_done", W'(frame_done), W'(e.fd));
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL latency: out at cycle %0d required %0d", cyc, e.due);
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] d;
    int           fd_base;
    int           out_base;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("idle_out_valid", W'(out_valid), '0);
      check("idle_dataout", DATAOUT, '0);
      check("idle_frame_done", W'(frame_done), '0);
    end

    // Ramp frame: every lane carries r*RW+c
    formula_mode = 1;
    for (int r = 0; r < RS; r++)
      for (int c = 0; c < RW; c++)
        send_beat({K{SW'(r*RW + c)}}, 0);
    formula_mode = 0;
    drain("ramp_frame");

    // Signed compares, lanes independent, in window (0,0)
    for (int r = 0; r < RS; r++)
      for (int c = 0; c < RW; c++) begin
        d = rnd_beat();
        if (r == 0 && c == 0) d = {32'h7FFFFFFF, 32'd7,         32'hFFFFFFFB};
        if (r == 0 && c == 1) d = {32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFD};
        if (r == 1 && c == 0) d = {32'h7FFFFFFF, 32'd2,         32'hFFFFFFF7};
        if (r == 1 && c == 1) begin
          d = {32'h7FFFFFFF, 32'd7, 32'hFFFFFFFF};
          hand_val = {32'h7FFFFFFF, 32'd7, 32'hFFFFFFFF};
          hand_pending = 1;
        end
        send_beat(d, 0);
      end
    drain("signed_frame");

    // Random gaps of 0..3 cycles anywhere
    for (int n = 0; n < RW*RS; n++)
      send_beat(rnd_beat(), $urandom_range(0, 3));
    drain("gap_frame");

    // Reset in the middle of a frame
    for (int n = 0; n < 700; n++)
      send_beat(rnd_beat(), 0);
    drain("pre_reset");
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      in_valid = 1'b1;
      DATAIN   = rnd_beat();
      @(negedge clk);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    mr = 0;
    mc = 0;
    check("reset_out_valid", W'(out_valid), '0);
    check("reset_dataout", DATAOUT, '0);
    check("reset_frame_done", W'(frame_done), '0);
    idle(3);
    for (int n = 0; n < RW*RS; n++)
      send_beat(rnd_beat(), 0);
    drain("post_reset_frame");

    // Two frames back to back
    fd_base  = fd_count;
    out_base = out_count;
    for (int n = 0; n < 2*RW*RS; n++)
      send_beat(rnd_beat(), 0);
    drain("double_frame");
    idle(2);
    check("double_frame_done_count", W'(fd_count - fd_base), W'(2));
    check("double_frame_out_count", W'(out_count - out_base), W'(2*(RW/2)*(RS/2)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
